// File: rtl/ifm_row_feeder.sv
// ---------------------------------------------------------------------------
// ifm_row_feeder
//
// Streams one IFM row from the on-chip IFM SRAM into the PE-side IFM shift
// buffer. After an accepted start it reads num_cols pixels from
// row_base+col. Addresses wrap modulo 2^ADDR_W. The SRAM has a one-cycle read
// latency. Each pixel is handed downstream with the ifm_input/ifm_read pair.
// A one-entry skid register catches the pixel that is in flight when stall
// rises, so no pixel is lost or duplicated.
//
// Parameters
//   ADDR_W  IFM SRAM address width
//   COL_W   width of num_cols and the column/delivery counters
//   KSIZE   window depth; win_valid rises after KSIZE deliveries
//
// Ports
//   clk        in   1       clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   start      in   1       row request, sampled only in IDLE
//   row_base   in   ADDR_W  first SRAM address of the row
//   num_cols   in   COL_W   number of pixels in the row
//   stall      in   1       downstream not ready
//   mem_en     out  1       SRAM read enable
//   mem_addr   out  ADDR_W  SRAM read address
//   mem_rdata  in   8       signed SRAM data, valid the cycle after mem_en
//   ifm_input  out  8       signed pixel to the IFM buffer
//   ifm_read   out  1       ifm_input valid and consumed this cycle
//   win_valid  out  1       downstream holds KSIZE pixels of this row
//   busy       out  1       row in progress (FETCH or DRAIN)
//   done       out  1       one-cycle pulse when the row is fully delivered
// ---------------------------------------------------------------------------
module ifm_row_feeder #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned COL_W  = 6,
  parameter int unsigned KSIZE  = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        row_base,
  input  logic [COL_W-1:0]         num_cols,
  input  logic                     stall,
  output logic                     mem_en,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic signed [7:0]        mem_rdata,
  output logic signed [7:0]        ifm_input,
  output logic                     ifm_read,
  output logic                     win_valid,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      base_q, base_d;
  logic [COL_W-1:0]       ncols_q, ncols_d;
  logic [COL_W-1:0]       col_q, col_d;
  logic [COL_W-1:0]       dcnt_q, dcnt_d;
  logic                   win_q, win_d;
  logic                   rd_pend_q;
  logic                   skid_v_q, skid_v_d;
  logic signed [7:0]      skid_q, skid_d;
  logic                   fetch_en;

  // ---------------------------------------------------------------------
  // Read issue
  // ---------------------------------------------------------------------
  // Reads are gated by stall. While stall is high at most one pixel can be
  // in flight, and the skid register absorbs it.
  assign fetch_en = (state_q == S_FETCH) & ~stall;
  assign mem_en   = fetch_en;
  assign mem_addr = (state_q == S_FETCH) ? (base_q + ADDR_W'(col_q)) : '0;

  // ---------------------------------------------------------------------
  // Return path
  // ---------------------------------------------------------------------
  // The skid pixel is older than any pixel arriving from the SRAM, so it
  // has priority. In practice both are never valid in the same cycle.
  assign ifm_read  = (skid_v_q | rd_pend_q) & ~stall;
  assign ifm_input = ifm_read ? (skid_v_q ? skid_q : mem_rdata) : '0;
  assign win_valid = win_q;

  always_comb begin
    skid_v_d = skid_v_q;
    skid_d   = skid_q;
    if (rd_pend_q & stall & ~skid_v_q) begin
      skid_v_d = 1'b1;
      skid_d   = mem_rdata;
    end else if (skid_v_q & ~stall) begin
      skid_v_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Control FSM: next state, counters and status outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    ncols_d = ncols_q;
    col_d   = col_q;
    dcnt_d  = dcnt_q;
    win_d   = win_q;
    busy    = 1'b0;
    done    = 1'b0;

    if (ifm_read) begin
      dcnt_d = dcnt_q + COL_W'(1);
      if (dcnt_q == COL_W'(KSIZE - 1)) begin
        win_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = row_base;
          ncols_d = num_cols;
          col_d   = '0;
          dcnt_d  = '0;
          win_d   = 1'b0;
          state_d = (num_cols == '0) ? S_DONE : S_FETCH;
        end
      end

      S_FETCH: begin
        busy = 1'b1;
        if (fetch_en) begin
          col_d = col_q + COL_W'(1);
          if (col_q == ncols_q - COL_W'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end

      // Leave as soon as the final delivery is counted. DONE then falls in
      // the cycle directly after the last ifm_read.
      S_DRAIN: begin
        busy = 1'b1;
        if (dcnt_d == ncols_q) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      ncols_q   <= '0;
      col_q     <= '0;
      dcnt_q    <= '0;
      win_q     <= 1'b0;
      rd_pend_q <= 1'b0;
      skid_v_q  <= 1'b0;
      skid_q    <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      ncols_q   <= ncols_d;
      col_q     <= col_d;
      dcnt_q    <= dcnt_d;
      win_q     <= win_d;
      rd_pend_q <= mem_en;
      skid_v_q  <= skid_v_d;
      skid_q    <= skid_d;
    end
  end

endmodule

// File: tb/tb_ifm_row_feeder.sv
module tb_ifm_row_feeder;

  localparam int KSIZE = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [5:0]        row_base;
  logic [5:0]        num_cols;
  logic              stall;
  logic              mem_en;
  logic [5:0]        mem_addr;
  logic signed [7:0] mem_rdata;
  logic signed [7:0] ifm_input;
  logic              ifm_read;
  logic              win_valid;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;

  logic signed [7:0] mem [64];

  ifm_row_feeder #(.ADDR_W(6), .COL_W(6), .KSIZE(KSIZE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .row_base  (row_base),
    .num_cols  (num_cols),
    .stall     (stall),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .ifm_input (ifm_input),
    .ifm_read  (ifm_read),
    .win_valid (win_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // SRAM model: one-cycle latency, junk on the bus when not reading.
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= mem[mem_addr];
    else        mem_rdata <= 8'($urandom);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, $signed(act), $signed(exp), $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mem_en"},    mem_en,    0);
    chk({tag, "_mem_addr"},  mem_addr,  0);
    chk({tag, "_ifm_read"},  ifm_read,  0);
    chk({tag, "_ifm_input"}, ifm_input, 0);
    chk({tag, "_win_valid"}, win_valid, 0);
    chk({tag, "_busy"},      busy,      0);
    chk({tag, "_done"},      done,      0);
  endtask

  // Runs one row. Entered and left at posedge+1. Cycle 0 is the start
  // cycle. Stall is high in cycles lo..hi, or random with pst percent if
  // lo<0. When repulse is nonzero, start is re-pulsed with different
  // operands in that cycle. The scoreboard expects pixels in order from
  // mem[base+i], one done pulse in the cycle after the last delivery, and
  // win_valid once KSIZE pixels have gone out.
  task automatic run_row(input logic [5:0] base, input logic [5:0] n,
                         input int lo, input int hi, input int repulse,
                         input int pst, output int done_c, output int win_c);
    int   issued, deliv, last_deliv, cyc;
    logic fin, exp_dn;
    logic [5:0] a;
    issued = 0; deliv = 0; last_deliv = 0; cyc = 0; fin = 0;
    done_c = -1; win_c = -1;
    while (!fin && cyc < 1000) begin
      start    = (cyc == 0) || (repulse != 0 && cyc == repulse);
      row_base = (cyc == 0) ? base : ~base;
      num_cols = (cyc == 0) ? n : n + 6'd3;
      if (lo >= 0) stall = (cyc >= lo && cyc <= hi);
      else         stall = ($urandom_range(99) < pst);
      @(negedge clk);
      chk("mem_en_while_stall", mem_en & stall, 0);
      chk("ifm_read_while_stall", ifm_read & stall, 0);
      if (cyc >= 1) begin
        chk("win_valid", win_valid, deliv >= KSIZE);
        if (win_valid && win_c < 0) win_c = cyc;
      end
      exp_dn = (n == 0) ? (cyc == 1) : (deliv == n && cyc == last_deliv + 1);
      chk("done", done, exp_dn);
      chk("busy", busy, (n != 0) && (cyc >= 1) && !exp_dn);
      if (done) done_c = cyc;
      if (mem_en) begin
        chk("issue_in_range", (issued < n) && (cyc >= 1), 1);
        a = base + 6'(issued);
        chk("mem_addr", mem_addr, a);
        issued++;
      end
      if (ifm_read) begin
        chk("deliv_in_range", deliv < n, 1);
        a = base + 6'(deliv);
        chk("ifm_input", ifm_input, mem[a]);
        deliv++;
        last_deliv = cyc;
      end else begin
        chk("ifm_input_idle", ifm_input, 0);
      end
      fin = exp_dn | done;
      @(posedge clk); #1;
      cyc++;
    end
    chk("row_complete", fin, 1);
    chk("row_deliveries", deliv, n);
    start = 0;
    stall = 1'($urandom_range(1));
    @(negedge clk);
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    chk("post_mem_en", mem_en, 0);
    chk("post_ifm_read", ifm_read, 0);
    @(posedge clk); #1;
    stall = 0;
  endtask

  typedef struct {
    logic [5:0] base;
    logic [5:0] n;
    int         lo;
    int         hi;
    int         repulse;
    int         exp_done;
    int         exp_win;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int dc, wc, pst, rep;
    logic [5:0] b, n;

    tbl[0] = '{6'd10, 6'd5, 99, 0,  0, 7,  5};   // plain row
    tbl[1] = '{6'd10, 6'd5, 3,  4,  0, 9,  7};   // stall in cycles 3-4, skid used
    tbl[2] = '{6'd10, 6'd0, 99, 0,  0, 1,  -1};  // empty row
    tbl[3] = '{6'd62, 6'd4, 99, 0,  0, 6,  5};   // address wrap
    tbl[4] = '{6'd10, 6'd5, 1,  10, 0, 17, 15};  // long stall from start
    tbl[5] = '{6'd10, 6'd5, 99, 0,  3, 7,  5};   // start re-pulsed while busy
    tbl[6] = '{6'd7,  6'd3, 4,  4,  0, 6,  6};   // stall on the last delivery
    tbl[7] = '{6'd40, 6'd1, 99, 0,  0, 3,  -1};  // single pixel

    for (int i = 0; i < 64; i++) mem[i] = 8'(i + 1);

    rst_n = 0; start = 0; stall = 0; row_base = '0; num_cols = '0;
    #1;
    chk_zero("reset_async");
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset_held");
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;

    for (int v = 0; v < 8; v++) begin
      run_row(tbl[v].base, tbl[v].n, tbl[v].lo, tbl[v].hi, tbl[v].repulse, 0, dc, wc);
      chk($sformatf("tbl%0d_done_cycle", v), dc, tbl[v].exp_done);
      chk($sformatf("tbl%0d_win_cycle", v), wc, tbl[v].exp_win);
    end

    // Reset in the middle of a row: outputs drop at once, no done follows,
    // and the next row is clean.
    start = 1; row_base = 6'd5; num_cols = 6'd10; stall = 0;
    @(posedge clk); #1;
    start = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("midrow_win_before_reset", win_valid, 1);
    chk("midrow_busy_before_reset", busy, 1);
    rst_n = 0;
    #1;
    chk_zero("midrow_reset");
    repeat (2) begin
      @(negedge clk);
      chk("reset_no_done", done, 0);
    end
    rst_n = 1;
    @(posedge clk); #1;
    run_row(6'd20, 6'd6, 99, 0, 0, 0, dc, wc);
    chk("after_reset_done_cycle", dc, 8);
    chk("after_reset_win_cycle", wc, 5);

    // Randomised rows against the scoreboard.
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    for (int r = 0; r < 40; r++) begin
      b   = 6'($urandom);
      n   = 6'($urandom_range(0, 24));
      case ($urandom_range(3))
        0:       pst = 0;
        1:       pst = 20;
        2:       pst = 50;
        default: pst = 80;
      endcase
      rep = ($urandom_range(3) == 0) ? $urandom_range(2, 6) : 0;
      run_row(b, n, -1, 0, rep, pst, dc, wc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
